// File: rtl/ternary_seq_ctrl_if.sv
// Command, loader and MAC-array signals of the ternary sequencing controller.
// master = command/loader side, slave = the controller itself.
interface ternary_seq_ctrl_if;
    logic       ena;
    logic       cmd_load;
    logic       cmd_run;
    logic [6:0] cfg_param;
    logic [6:0] ld_param;
    logic       ld_ena;
    logic       ld_done;
    logic       weights_valid;
    logic       mac_en;
    logic [2:0] mac_col;
    logic       out_valid;
    logic [2:0] out_idx;
    logic       out_last;
    logic       busy;
    logic       err;

    modport master (
        output ena, cmd_load, cmd_run, cfg_param, ld_done,
        input  ld_param, ld_ena, weights_valid, mac_en, mac_col,
               out_valid, out_idx, out_last, busy, err
    );

    modport slave (
        input  ena, cmd_load, cmd_run, cfg_param, ld_done,
        output ld_param, ld_ena, weights_valid, mac_en, mac_col,
               out_valid, out_idx, out_last, busy, err
    );
endinterface

// File: rtl/ternary_seq_ctrl.sv
// Sequencing controller: drives the weight loader for 2N beats, confirms completion,
// then steps the MAC array through N columns with a MAC_LAT-deep result strobe pipeline.
module ternary_seq_ctrl #(
    parameter int MAX_IN_LEN  = 16,
    parameter int MAX_OUT_LEN = 8,
    parameter int MAC_LAT     = 1
) (
    input logic               clk,
    input logic               rst_n,
    ternary_seq_ctrl_if.slave bus
);
    localparam int COL_W = $clog2(MAX_OUT_LEN);
    localparam int CFG_W = $clog2(MAX_IN_LEN) + COL_W;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_SETTLE = 3'd3;
    localparam logic [2:0] S_READY  = 3'd4;
    localparam logic [2:0] S_RUN    = 3'd5;
    localparam logic [2:0] S_DRAIN  = 3'd6;

    logic [2:0]       state;
    logic [CFG_W-1:0] cfg_q;
    logic [COL_W:0]   beat;
    logic [COL_W-1:0] col;
    logic [1:0]       wait_cnt;
    logic [1:0]       drain_cnt;
    logic             wv_q;
    logic             err_q;
    // Each stage holds {valid, last, column}
    logic [COL_W+1:0] pipe [MAC_LAT];

    logic [COL_W-1:0] last_col;
    logic             busy_st;
    logic             run_now;
    logic             last_now;
    logic [COL_W+1:0] pipe_in;
    logic             abort;
    logic             cmd_err;
    logic             timeout;

    assign last_col = cfg_q[COL_W-1:0];
    assign busy_st  = (state == S_LOAD) || (state == S_WAIT) || (state == S_SETTLE) ||
                      (state == S_RUN)  || (state == S_DRAIN);
    assign run_now  = (state == S_RUN);
    assign last_now = run_now && (col == last_col);
    assign pipe_in  = {run_now, last_now, run_now ? col : '0};

    // Dropping ena while busy aborts; commands only count while ena is high
    assign abort    = busy_st && !bus.ena;
    assign cmd_err  = bus.ena && ((busy_st && (bus.cmd_load || bus.cmd_run)) ||
                                  ((state == S_IDLE) && bus.cmd_run) ||
                                  ((state == S_READY) && bus.cmd_load && bus.cmd_run));
    assign timeout  = (state == S_WAIT) && bus.ena && !bus.ld_done && (wait_cnt == 2'd3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cfg_q     <= '0;
            beat      <= '0;
            col       <= '0;
            wait_cnt  <= '0;
            drain_cnt <= '0;
            wv_q      <= 1'b0;
            err_q     <= 1'b0;
            for (int i = 0; i < MAC_LAT; i++) pipe[i] <= '0;
        end else begin
            err_q   <= abort || cmd_err || timeout;
            pipe[0] <= pipe_in;
            for (int i = 1; i < MAC_LAT; i++) pipe[i] <= pipe[i-1];

            if (abort) begin
                state <= S_IDLE;
                wv_q  <= 1'b0;
                for (int i = 0; i < MAC_LAT; i++) pipe[i] <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (bus.ena && bus.cmd_load) begin
                            cfg_q <= bus.cfg_param;
                            beat  <= '0;
                            state <= S_LOAD;
                        end
                    end
                    // Two beats (MSB and LSB plane) per output column
                    S_LOAD: begin
                        if (beat == {last_col, 1'b1}) begin
                            wait_cnt <= '0;
                            state    <= S_WAIT;
                        end else begin
                            beat <= beat + 1'b1;
                        end
                    end
                    S_WAIT: begin
                        if (bus.ld_done) begin
                            state <= S_SETTLE;
                        end else if (wait_cnt == 2'd3) begin
                            state <= S_IDLE;
                        end else begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end
                    end
                    S_SETTLE: begin
                        wv_q  <= 1'b1;
                        state <= S_READY;
                    end
                    S_READY: begin
                        if (bus.ena && bus.cmd_load) begin
                            cfg_q <= bus.cfg_param;
                            beat  <= '0;
                            wv_q  <= 1'b0;
                            state <= S_LOAD;
                        end else if (bus.ena && bus.cmd_run) begin
                            col   <= '0;
                            state <= S_RUN;
                        end
                    end
                    S_RUN: begin
                        if (col == last_col) begin
                            drain_cnt <= '0;
                            state     <= S_DRAIN;
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                    S_DRAIN: begin
                        if (drain_cnt == 2'(MAC_LAT - 1)) begin
                            state <= S_READY;
                        end else begin
                            drain_cnt <= drain_cnt + 1'b1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.ld_param      = cfg_q;
    assign bus.ld_ena        = (state == S_LOAD);
    assign bus.weights_valid = wv_q;
    assign bus.mac_en        = run_now;
    assign bus.mac_col       = pipe_in[COL_W-1:0];
    assign bus.out_valid     = pipe[MAC_LAT-1][COL_W+1];
    assign bus.out_last      = pipe[MAC_LAT-1][COL_W];
    assign bus.out_idx       = pipe[MAC_LAT-1][COL_W-1:0];
    assign bus.busy          = busy_st;
    assign bus.err           = err_q;
endmodule

// File: tb/tb_ternary_seq_ctrl.sv
// Table-driven bench for ternary_seq_ctrl (MAC_LAT=2) plus hand sequences
// for abort, timeout and asynchronous reset corners.
module tb_ternary_seq_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    ternary_seq_ctrl_if bus ();

    ternary_seq_ctrl #(
        .MAX_IN_LEN (16),
        .MAX_OUT_LEN(8),
        .MAC_LAT    (2)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    localparam logic [6:0] P7B = 7'h7B;
    localparam logic [6:0] P28 = 7'h28;
    localparam logic [6:0] P5A = 7'h5A;

    typedef struct {
        string       name;
        logic        ena;
        logic        ld;
        logic        run;
        logic        done;
        logic [6:0]  cfg;
        logic [19:0] exp;
    } vec_t;

    vec_t tbl[$];
    int   vec_count  = 0;
    int   miss_count = 0;

    logic [19:0] act;
    assign act = {bus.ld_param, bus.ld_ena, bus.weights_valid, bus.busy, bus.err,
                  bus.mac_en, bus.mac_col, bus.out_valid, bus.out_idx, bus.out_last};

    // Expected packing: param, ld_ena, weights_valid, busy, err, mac_en, mac_col, out_valid, out_idx, out_last
    function automatic logic [19:0] pk(input logic [6:0] p, input logic le, input logic wv,
                                       input logic bz, input logic er, input logic me,
                                       input logic [2:0] mc, input logic ov,
                                       input logic [2:0] oi, input logic ol);
        return {p, le, wv, bz, er, me, mc, ov, oi, ol};
    endfunction

    task automatic add_vec(input string name, input logic e, input logic l, input logic r,
                           input logic d, input logic [6:0] c, input logic [19:0] x);
        vec_t v;
        v.name = name; v.ena = e; v.ld = l; v.run = r; v.done = d; v.cfg = c; v.exp = x;
        tbl.push_back(v);
    endtask

    task automatic applyStimulus(input logic e, input logic l, input logic r,
                                 input logic d, input logic [6:0] c);
        bus.ena       = e;
        bus.cmd_load  = l;
        bus.cmd_run   = r;
        bus.ld_done   = d;
        bus.cfg_param = c;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [19:0] exp);
        vec_count++;
        if (act !== exp) begin
            miss_count++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Loads cfg and walks it to READY, checking every cycle along the way
    task automatic load_to_ready(input logic [6:0] cfg);
        int n;
        n = int'(cfg[2:0]) + 1;
        applyStimulus(1, 1, 0, 0, cfg);
        checkOutput("l2r_accept", pk(cfg, 1, 0, 1, 0, 0, 0, 0, 0, 0));
        for (int i = 1; i < 2 * n; i++) begin
            applyStimulus(1, 0, 0, 0, cfg);
            checkOutput("l2r_beat", pk(cfg, 1, 0, 1, 0, 0, 0, 0, 0, 0));
        end
        applyStimulus(1, 0, 0, 0, cfg);
        checkOutput("l2r_wait", pk(cfg, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        applyStimulus(1, 0, 0, 1, cfg);
        checkOutput("l2r_settle", pk(cfg, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        applyStimulus(1, 0, 0, 0, cfg);
        checkOutput("l2r_ready", pk(cfg, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    endtask

    initial begin
        bus.ena = 0; bus.cmd_load = 0; bus.cmd_run = 0; bus.ld_done = 0; bus.cfg_param = '0;

        // N=4 load, handshake, then a full run with MAC_LAT=2 drain
        add_vec("load_accept", 1, 1, 0, 0, P7B, pk(P7B, 1, 0, 1, 0, 0, 0, 0, 0, 0));
        for (int i = 1; i < 8; i++)
            add_vec("load_beat", 1, 0, 0, 0, P7B, pk(P7B, 1, 0, 1, 0, 0, 0, 0, 0, 0));
        add_vec("wait_done",  1, 0, 0, 0, P7B, pk(P7B, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        add_vec("settle",     1, 0, 0, 1, P7B, pk(P7B, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        add_vec("ready",      1, 0, 0, 0, P7B, pk(P7B, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        add_vec("run_c0",     1, 0, 1, 0, P7B, pk(P7B, 0, 1, 1, 0, 1, 0, 0, 0, 0));
        add_vec("run_c1",     1, 0, 0, 0, P7B, pk(P7B, 0, 1, 1, 0, 1, 1, 0, 0, 0));
        add_vec("run_c2",     1, 0, 0, 0, P7B, pk(P7B, 0, 1, 1, 0, 1, 2, 1, 0, 0));
        add_vec("run_c3",     1, 0, 0, 0, P7B, pk(P7B, 0, 1, 1, 0, 1, 3, 1, 1, 0));
        add_vec("drain_0",    1, 0, 0, 0, P7B, pk(P7B, 0, 1, 1, 0, 0, 0, 1, 2, 0));
        add_vec("drain_1",    1, 0, 0, 0, P7B, pk(P7B, 0, 1, 1, 0, 0, 0, 1, 3, 1));
        add_vec("ready_2",    1, 0, 0, 0, P7B, pk(P7B, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        // cmd_run during RUN flags err without disturbing the run
        add_vec("rerun_c0",   1, 0, 1, 0, P7B, pk(P7B, 0, 1, 1, 0, 1, 0, 0, 0, 0));
        add_vec("run_err",    1, 0, 1, 0, P7B, pk(P7B, 0, 1, 1, 1, 1, 1, 0, 0, 0));
        add_vec("rerun_c2",   1, 0, 0, 0, P7B, pk(P7B, 0, 1, 1, 0, 1, 2, 1, 0, 0));
        add_vec("rerun_c3",   1, 0, 0, 0, P7B, pk(P7B, 0, 1, 1, 0, 1, 3, 1, 1, 0));
        add_vec("redrain_0",  1, 0, 0, 0, P7B, pk(P7B, 0, 1, 1, 0, 0, 0, 1, 2, 0));
        add_vec("redrain_1",  1, 0, 0, 0, P7B, pk(P7B, 0, 1, 1, 0, 0, 0, 1, 3, 1));
        add_vec("ready_3",    1, 0, 0, 0, P7B, pk(P7B, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        // N=1: two load beats, single column run
        add_vec("n1_load",    1, 1, 0, 0, P28, pk(P28, 1, 0, 1, 0, 0, 0, 0, 0, 0));
        add_vec("n1_beat",    1, 0, 0, 0, P28, pk(P28, 1, 0, 1, 0, 0, 0, 0, 0, 0));
        add_vec("n1_wait",    1, 0, 0, 0, P28, pk(P28, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        add_vec("n1_settle",  1, 0, 0, 1, P28, pk(P28, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        add_vec("n1_ready",   1, 0, 0, 0, P28, pk(P28, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        add_vec("n1_run",     1, 0, 1, 0, P28, pk(P28, 0, 1, 1, 0, 1, 0, 0, 0, 0));
        add_vec("n1_drain0",  1, 0, 0, 0, P28, pk(P28, 0, 1, 1, 0, 0, 0, 0, 0, 0));
        add_vec("n1_drain1",  1, 0, 0, 0, P28, pk(P28, 0, 1, 1, 0, 0, 0, 1, 0, 1));
        add_vec("n1_ready2",  1, 0, 0, 0, P28, pk(P28, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        // load+run together: load wins with err, then ld_done never arrives
        add_vec("ldrun_both", 1, 1, 1, 0, P7B, pk(P7B, 1, 0, 1, 1, 0, 0, 0, 0, 0));
        for (int i = 1; i < 8; i++)
            add_vec("ldrun_beat", 1, 0, 0, 0, P7B, pk(P7B, 1, 0, 1, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 4; i++)
            add_vec("to_wait",  1, 0, 0, 0, P7B, pk(P7B, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        add_vec("timeout",    1, 0, 0, 0, P7B, pk(P7B, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        add_vec("idle_quiet", 1, 0, 0, 0, P7B, pk(P7B, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        add_vec("idle_ena0",  0, 0, 1, 0, P7B, pk(P7B, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        add_vec("idle_run",   1, 0, 1, 0, P7B, pk(P7B, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        add_vec("idle_after", 1, 0, 0, 0, P7B, pk(P7B, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        #1;
        checkOutput("reset_state", pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(0, 0, 0, 0, '0);
        checkOutput("idle_post_reset", pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        foreach (tbl[i]) begin
            applyStimulus(tbl[i].ena, tbl[i].ld, tbl[i].run, tbl[i].done, tbl[i].cfg);
            checkOutput(tbl[i].name, tbl[i].exp);
        end

        // ena dropped during the third LOAD beat
        applyStimulus(1, 1, 0, 0, P5A);
        checkOutput("ab_beat1", pk(P5A, 1, 0, 1, 0, 0, 0, 0, 0, 0));
        applyStimulus(1, 0, 0, 0, P5A);
        checkOutput("ab_beat2", pk(P5A, 1, 0, 1, 0, 0, 0, 0, 0, 0));
        applyStimulus(1, 0, 0, 0, P5A);
        checkOutput("ab_beat3", pk(P5A, 1, 0, 1, 0, 0, 0, 0, 0, 0));
        applyStimulus(0, 0, 0, 0, P5A);
        checkOutput("abort_load", pk(P5A, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        applyStimulus(1, 0, 0, 0, P5A);
        checkOutput("abort_idle", pk(P5A, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        // Fresh load after abort, then abort mid-RUN must flush the result pipeline
        load_to_ready(P7B);
        applyStimulus(1, 0, 1, 0, P7B);
        checkOutput("ar_c0", pk(P7B, 0, 1, 1, 0, 1, 0, 0, 0, 0));
        applyStimulus(1, 0, 0, 0, P7B);
        checkOutput("ar_c1", pk(P7B, 0, 1, 1, 0, 1, 1, 0, 0, 0));
        applyStimulus(1, 0, 0, 0, P7B);
        checkOutput("ar_c2", pk(P7B, 0, 1, 1, 0, 1, 2, 1, 0, 0));
        applyStimulus(0, 0, 0, 0, P7B);
        checkOutput("abort_run", pk(P7B, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        applyStimulus(1, 0, 0, 0, P7B);
        checkOutput("abort_run_idle", pk(P7B, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        // Asynchronous reset mid-RUN clears everything without a clock edge
        load_to_ready(P5A);
        applyStimulus(1, 0, 1, 0, P5A);
        checkOutput("rr_c0", pk(P5A, 0, 1, 1, 0, 1, 0, 0, 0, 0));
        applyStimulus(1, 0, 0, 0, P5A);
        checkOutput("rr_c1", pk(P5A, 0, 1, 1, 0, 1, 1, 0, 0, 0));
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset", pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1, 0, 0, 0, P5A);
        checkOutput("post_reset_idle", pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        applyStimulus(1, 1, 0, 0, P7B);
        checkOutput("post_reset_load", pk(P7B, 1, 0, 1, 0, 0, 0, 0, 0, 0));

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end
endmodule
